// File: rtl/if_id_queue.sv
// if_id_queue
//   Instruction queue between the byte-serial fetch stage and decode.
//   Holds up to DEPTH completed {pc, inst} words from fetch and hands them
//   to decode in order over a valid/ready handshake. A flush empties the
//   queue in one cycle on a redirect.
//
// Ports
//   dclk        clock, all state updates on posedge
//   rst         asynchronous active-high reset
//   rdy         global ready; low freezes all state
//   inst_i      instruction word from fetch
//   pc_i        PC of inst_i
//   valid_i     fetch offers inst_i/pc_i this cycle
//   ready_o     queue accepts a push (rdy & ~full)
//   flush_i     discard all entries
//   ready_i     decode accepts the head entry
//   valid_ID_o  head entry valid (rdy & non-empty)
//   inst_ID_o   head instruction, NOP (addi x0,x0,0) when empty
//   pc_ID_o     head PC, 0 when empty
//   count_o     current occupancy, 0..DEPTH
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             dclk,
  input  logic             rst,
  input  logic             rdy,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      pc_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             flush_i,
  input  logic             ready_i,
  output logic             valid_ID_o,
  output logic [31:0]      inst_ID_o,
  output logic [31:0]      pc_ID_o,
  output logic [PTR_W:0]   count_o
);

  localparam logic [31:0]    NOP      = 32'h0000_0013;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [63:0]      mem [DEPTH];
  logic [PTR_W-1:0] rd;
  logic [PTR_W-1:0] wr;
  logic [PTR_W:0]   count;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  // Handshake outputs come only from registered state and rdy, so there is
  // no combinational path from valid_i or ready_i to either of them.
  assign ready_o    = rdy & ~full;
  assign valid_ID_o = rdy & ~empty;

  assign push = valid_i & ready_o;
  assign pop  = valid_ID_o & ready_i;

  // Show-ahead head; still reflects the stored head while rdy is low.
  assign inst_ID_o = empty ? NOP   : mem[rd][31:0];
  assign pc_ID_o   = empty ? 32'h0 : mem[rd][63:32];
  assign count_o   = count;

  // Control state: pointers and occupancy. Flush only acts while rdy is
  // high and overrides any push/pop in the same cycle.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else if (rdy) begin
      if (flush_i) begin
        rd    <= '0;
        wr    <= '0;
        count <= '0;
      end else begin
        if (push) wr <= wr + PTR_W'(1);
        if (pop)  rd <= rd + PTR_W'(1);
        if (push && !pop)      count <= count + (PTR_W + 1)'(1);
        else if (pop && !push) count <= count - (PTR_W + 1)'(1);
      end
    end
  end

  // Storage: cleared on reset; a push during a flush is dropped.
  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush_i) begin
      mem[wr] <= {pc_i, inst_i};
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
module tb_if_id_queue;

  localparam int DEPTH = 2;
  localparam int PW    = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          dclk = 1'b0;
  logic          rst;
  logic          rdy;
  logic [31:0]   inst_i;
  logic [31:0]   pc_i;
  logic          valid_i;
  logic          ready_o;
  logic          flush_i;
  logic          ready_i;
  logic          valid_ID_o;
  logic [31:0]   inst_ID_o;
  logic [31:0]   pc_ID_o;
  logic [PW:0]   count_o;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: an ordered list of {pc, inst} words.
  logic [63:0] q[$];

  if_id_queue #(.DEPTH(DEPTH)) dut (
    .dclk       (dclk),
    .rst        (rst),
    .rdy        (rdy),
    .inst_i     (inst_i),
    .pc_i       (pc_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .flush_i    (flush_i),
    .ready_i    (ready_i),
    .valid_ID_o (valid_ID_o),
    .inst_ID_o  (inst_ID_o),
    .pc_ID_o    (pc_ID_o),
    .count_o    (count_o)
  );

  always #5 dclk = ~dclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    int n;
    n = q.size();
    check({tag, ".count"}, 64'(count_o), 64'(n));
    check({tag, ".ready_o"}, 64'(ready_o), 64'(rdy && (n < DEPTH)));
    check({tag, ".valid"}, 64'(valid_ID_o), 64'(rdy && (n > 0)));
    check({tag, ".inst"}, 64'(inst_ID_o), (n > 0) ? 64'(q[0][31:0]) : 64'(NOP));
    check({tag, ".pc"}, 64'(pc_ID_o), (n > 0) ? 64'(q[0][63:32]) : 64'h0);
  endtask

  // Called just after a negedge: drive, check outputs, cross one posedge,
  // update the model, and return at the next negedge.
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [31:0] in, input logic [31:0] p,
                      input logic f, input logic ri);
    bit do_push, do_pop;
    rdy = r; valid_i = v; inst_i = in; pc_i = p; flush_i = f; ready_i = ri;
    #1;
    check_outputs(tag);
    do_push = r && v && (q.size() < DEPTH);
    do_pop  = r && ri && (q.size() > 0);
    @(posedge dclk);
    if (r) begin
      if (f) q.delete();
      else begin
        if (do_pop)  void'(q.pop_front());
        if (do_push) q.push_back({p, in});
      end
    end
    @(negedge dclk);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; valid_i = 1'b0; inst_i = '0; pc_i = '0;
    flush_i = 1'b0; ready_i = 1'b0;
    #2;
    // Reset values while rst is held
    check("rst.valid", 64'(valid_ID_o), 64'h0);
    check("rst.inst", 64'(inst_ID_o), 64'(NOP));
    check("rst.pc", 64'(pc_ID_o), 64'h0);
    check("rst.count", 64'(count_o), 64'h0);
    check("rst.ready", 64'(ready_o), 64'h1);
    @(negedge dclk);
    rst = 1'b0;
    @(negedge dclk);

    step("idle", 1, 0, 32'h0, 32'h0, 0, 0);

    // Fill and drain
    step("fill0", 1, 1, 32'h0050_0093, 32'h0, 0, 0);
    step("fill1", 1, 1, 32'h0010_0113, 32'h4, 0, 0);
    step("fill2", 1, 1, 32'hDEAD_BEEF, 32'h8, 0, 0);
    check("full.count", 64'(count_o), 64'h2);
    check("full.ready", 64'(ready_o), 64'h0);
    check("full.head", 64'(inst_ID_o), 64'h0050_0093);
    step("drain0", 1, 0, 32'h0, 32'h0, 0, 1);
    check("drain.head1", 64'(inst_ID_o), 64'h0010_0113);
    check("drain.pc1", 64'(pc_ID_o), 64'h4);
    step("drain1", 1, 0, 32'h0, 32'h0, 0, 1);
    step("drain2", 1, 0, 32'h0, 32'h0, 0, 1);
    check("drain.nop", 64'(inst_ID_o), 64'(NOP));

    // Simultaneous push/pop at count=1, pointers wrap
    step("pp.seed", 1, 1, 32'h1000_0000, 32'h100, 0, 0);
    for (int i = 1; i <= 8; i++)
      step("pushpop", 1, 1, 32'h1000_0000 + 32'(i), 32'h100 + 32'(4 * i), 0, 1);
    check("pp.count", 64'(count_o), 64'h1);
    check("pp.last", 64'(inst_ID_o), 64'h1000_0008);
    step("pp.drain", 1, 0, 32'h0, 32'h0, 0, 1);

    // Flush with a push at count=2
    step("fl.a", 1, 1, 32'h2222_0001, 32'h200, 0, 0);
    step("fl.b", 1, 1, 32'h2222_0002, 32'h204, 0, 0);
    step("fl.go", 1, 1, 32'h2222_0003, 32'h208, 1, 1);
    check("fl.count", 64'(count_o), 64'h0);
    check("fl.valid", 64'(valid_ID_o), 64'h0);
    step("fl.next", 1, 1, 32'h3333_0001, 32'h300, 0, 0);
    check("fl.head", 64'(inst_ID_o), 64'h3333_0001);

    // rdy low for 3 cycles at count=1
    for (int i = 0; i < 3; i++)
      step("rdylow", 0, 1, 32'h4444_0000, 32'h400, 0, 1);
    check("rdylow.head", 64'(inst_ID_o), 64'h3333_0001);
    step("rdyhi.pop", 1, 0, 32'h0, 32'h0, 0, 1);

    // Async reset mid-drain at count=2
    step("ar.a", 1, 1, 32'h5555_0001, 32'h500, 0, 0);
    step("ar.b", 1, 1, 32'h5555_0002, 32'h504, 0, 0);
    ready_i = 1'b1; valid_i = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("ar.count", 64'(count_o), 64'h0);
    check("ar.valid", 64'(valid_ID_o), 64'h0);
    check("ar.inst", 64'(inst_ID_o), 64'(NOP));
    check("ar.pc", 64'(pc_ID_o), 64'h0);
    q.delete();
    #1 rst = 1'b0;
    @(negedge dclk);
    step("ar.push", 1, 1, 32'h6666_0001, 32'h600, 0, 0);
    check("ar.after", 64'(inst_ID_o), 64'h6666_0001);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++)
      step("rand", ($urandom_range(9) != 0), ($urandom_range(9) < 6), $urandom, $urandom,
           ($urandom_range(19) == 0), ($urandom_range(9) < 6));
    step("final", 1, 0, 32'h0, 32'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
